// File: rtl/pwm_pkg.sv
// Purpose: shared constants and types for the multi-channel PWM generator.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Holds the default counter/prescaler widths and the up/down direction type
// used when center-aligned counting (PWM_CENTER_ALIGN_EN) is compiled in.
package pwm_pkg;

   localparam int PWM_CNT_W_DEF = 16;
   localparam int PWM_PRE_W_DEF = 16;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Purpose: free-running clock prescaler producing a one-cycle tick every div+1 clocks.
// Latency: tick is combinational from the registered phase counter.
// Backpressure: none; enable=0 freezes the phase and suppresses tick.
//
// Ports: clock, reset (sync, active-high), enable, div (terminal count), tick.
module pwm_prescaler
   import pwm_pkg::*;
#(
   parameter int PRE_W = PWM_PRE_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [PRE_W-1:0] div,
   output logic             tick
);

   localparam logic [PRE_W-1:0] C_ONE = PRE_W'(1);

   logic [PRE_W-1:0] r_pre;
   logic             w_at_end;

   // '>=' rather than '==' so a divide value lowered while disabled cannot
   // strand the phase above the terminal count.
   assign w_at_end = (r_pre >= div);
   assign tick     = enable & w_at_end;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pre <= '0;
      end else if (enable) begin
         r_pre <= w_at_end ? '0 : r_pre + C_ONE;
      end
   end

endmodule

// File: rtl/pwm_generator_multi.sv
// Purpose: N_CH-channel PWM generator with shared prescaler, period counter and double-buffered config.
// Latency: pwm_out/period_tick registered, one clock after the count value they describe.
// Backpressure: none; enable=0 freezes counting and forces outputs low.
//
// Ports: clock, reset (sync, active-high), enable, prescale_div, period,
//        duty (channel i at [i*CNT_W +: CNT_W]), update (capture strobe),
//        update_pending, pwm_out, period_tick, count.
// Optional macro PWM_CENTER_ALIGN_EN adds input center_mode (captured with
// period) selecting up/down counting 0..period..0.
module pwm_generator_multi
   import pwm_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = PWM_CNT_W_DEF,
   parameter int PRE_W = PWM_PRE_W_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [PRE_W-1:0]      prescale_div,
   input  logic [CNT_W-1:0]      period,
   input  logic [N_CH*CNT_W-1:0] duty,
   input  logic                  update,
`ifdef PWM_CENTER_ALIGN_EN
   input  logic                  center_mode,
`endif
   output logic                  update_pending,
   output logic [N_CH-1:0]       pwm_out,
   output logic                  period_tick,
   output logic [CNT_W-1:0]      count
);

   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   // Shadow (active) and pending (captured) configuration.
   logic [PRE_W-1:0]      r_pre_sh,  r_pre_pd;
   logic [CNT_W-1:0]      r_per_sh,  r_per_pd;
   logic [N_CH*CNT_W-1:0] r_duty_sh, r_duty_pd;
   logic                  r_upd_pend;

   logic [CNT_W-1:0]      r_count;
   logic [N_CH-1:0]       r_pwm;
   logic                  r_ptick;

   logic                  w_tick;
   logic                  w_wrap;
   logic [CNT_W-1:0]      w_count_nxt;
   logic [N_CH-1:0]       w_cmp;

`ifdef PWM_CENTER_ALIGN_EN
   logic                  r_ctr_sh, r_ctr_pd;
   dir_e                  r_dir, w_dir_nxt;
`endif

   pwm_prescaler #(.PRE_W(PRE_W)) u_prescaler (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .div    (r_pre_sh),
      .tick   (w_tick)
   );

   // Next count and wrap detection. A wrap is the tick on which count
   // returns to 0; it drives period_tick and the shadow reload.
   always_comb begin
      w_count_nxt = r_count;
      w_wrap      = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      w_dir_nxt   = r_ctr_sh ? r_dir : DIR_UP;
`endif
      if (w_tick) begin
`ifdef PWM_CENTER_ALIGN_EN
         if (r_ctr_sh) begin
            if (r_dir == DIR_UP) begin
               if (r_count >= r_per_sh) begin
                  if (r_per_sh == '0) begin
                     w_count_nxt = '0;
                     w_wrap      = 1'b1;
                  end else begin
                     w_count_nxt = r_count - C_ONE;
                     w_dir_nxt   = DIR_DOWN;
                  end
               end else begin
                  w_count_nxt = r_count + C_ONE;
               end
            end else begin
               // Turning up at 0 marks the period boundary.
               if (r_count <= C_ONE) begin
                  w_count_nxt = '0;
                  w_dir_nxt   = DIR_UP;
                  w_wrap      = 1'b1;
               end else begin
                  w_count_nxt = r_count - C_ONE;
               end
            end
         end else
`endif
         if (r_count >= r_per_sh) begin
            w_count_nxt = '0;
            w_wrap      = 1'b1;
         end else begin
            w_count_nxt = r_count + C_ONE;
         end
      end
   end

   // Per-channel compares. In center mode the down leg uses '<=' so the
   // high pulse is symmetric about count 0 (2*duty ticks per period).
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [CNT_W-1:0] w_duty;
      assign w_duty = r_duty_sh[g*CNT_W +: CNT_W];
`ifdef PWM_CENTER_ALIGN_EN
      assign w_cmp[g] = (r_ctr_sh && (r_dir == DIR_DOWN)) ? (r_count <= w_duty)
                                                          : (r_count <  w_duty);
`else
      assign w_cmp[g] = (r_count < w_duty);
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pwm <= '0;
      end else begin
         r_pwm <= enable ? w_cmp : '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pre_sh   <= '0;
         r_per_sh   <= '0;
         r_duty_sh  <= '0;
         r_pre_pd   <= '0;
         r_per_pd   <= '0;
         r_duty_pd  <= '0;
         r_upd_pend <= 1'b0;
         r_count    <= '0;
         r_ptick    <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         r_ctr_sh   <= 1'b0;
         r_ctr_pd   <= 1'b0;
         r_dir      <= DIR_UP;
`endif
      end else begin
         r_ptick <= w_wrap;
         if (enable) begin
            r_count <= w_count_nxt;
`ifdef PWM_CENTER_ALIGN_EN
            r_dir   <= w_dir_nxt;
`endif
            // Apply the values pending before this cycle; a capture landing
            // on the wrap itself stays pending for the next wrap.
            if (w_wrap && r_upd_pend) begin
               r_pre_sh  <= r_pre_pd;
               r_per_sh  <= r_per_pd;
               r_duty_sh <= r_duty_pd;
`ifdef PWM_CENTER_ALIGN_EN
               r_ctr_sh  <= r_ctr_pd;
`endif
            end
            if (update) begin
               r_pre_pd   <= prescale_div;
               r_per_pd   <= period;
               r_duty_pd  <= duty;
`ifdef PWM_CENTER_ALIGN_EN
               r_ctr_pd   <= center_mode;
`endif
               r_upd_pend <= 1'b1;
            end else if (w_wrap) begin
               r_upd_pend <= 1'b0;
            end
         end else if (update) begin
            // Stopped: nothing to stay aligned with, load the shadows directly.
            r_pre_sh   <= prescale_div;
            r_per_sh   <= period;
            r_duty_sh  <= duty;
`ifdef PWM_CENTER_ALIGN_EN
            r_ctr_sh   <= center_mode;
`endif
            r_upd_pend <= 1'b0;
         end
      end
   end

   assign update_pending = r_upd_pend;
   assign pwm_out        = r_pwm;
   assign period_tick    = r_ptick;
   assign count          = r_count;

endmodule

// File: tb/tb_pwm_generator_multi.sv
// Purpose: self-checking bench for pwm_generator_multi (directed vectors + reference model).
// Latency: model predicts registered outputs one clock after the state they describe.
// Backpressure: n/a.
module tb_pwm_generator_multi;

   localparam int N_CH  = 4;
   localparam int CNT_W = 16;
   localparam int PRE_W = 16;

   logic                  clock = 1'b0;
   logic                  reset = 1'b1;
   logic                  enable = 1'b0;
   logic [PRE_W-1:0]      prescale_div = '0;
   logic [CNT_W-1:0]      period = '0;
   logic [N_CH*CNT_W-1:0] duty = '0;
   logic                  update = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
   logic                  center_mode = 1'b0;
`endif
   logic                  update_pending;
   logic [N_CH-1:0]       pwm_out;
   logic                  period_tick;
   logic [CNT_W-1:0]      count;

   pwm_generator_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .prescale_div   (prescale_div),
      .period         (period),
      .duty           (duty),
      .update         (update),
`ifdef PWM_CENTER_ALIGN_EN
      .center_mode    (center_mode),
`endif
      .update_pending (update_pending),
      .pwm_out        (pwm_out),
      .period_tick    (period_tick),
      .count          (count)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;
   bit model_on = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (edge-aligned) ----------------
   // Position within the period is one integer k of enabled clocks since the
   // last wrap: count = k/(pre+1), wrap when k reaches (per+1)*(pre+1).
   int              m_k, m_pre, m_per;
   int              m_duty [N_CH];
   int              p_pre, p_per;
   int              p_duty [N_CH];
   bit              p_flag;
   bit [N_CH-1:0]   m_pwm;
   bit              m_ptick;

   always @(posedge clock) begin : model
      int cnt;
      if (reset) begin
         m_k = 0; m_pre = 0; m_per = 0; p_pre = 0; p_per = 0;
         p_flag = 0; m_pwm = '0; m_ptick = 0;
         for (int c = 0; c < N_CH; c++) begin
            m_duty[c] = 0;
            p_duty[c] = 0;
         end
      end else if (enable) begin
         cnt = m_k / (m_pre + 1);
         for (int c = 0; c < N_CH; c++) m_pwm[c] = (cnt < m_duty[c]);
         m_k++;
         m_ptick = 0;
         if (m_k == (m_per + 1) * (m_pre + 1)) begin
            m_k = 0;
            m_ptick = 1;
            if (p_flag) begin
               m_pre = p_pre; m_per = p_per;
               for (int c = 0; c < N_CH; c++) m_duty[c] = p_duty[c];
            end
            p_flag = 0;
         end
         if (update) begin
            p_pre = int'(prescale_div); p_per = int'(period);
            for (int c = 0; c < N_CH; c++) p_duty[c] = int'(duty[c*CNT_W +: CNT_W]);
            p_flag = 1;
         end
      end else begin
         m_pwm = '0;
         m_ptick = 0;
         if (update) begin
            m_pre = int'(prescale_div); m_per = int'(period);
            for (int c = 0; c < N_CH; c++) m_duty[c] = int'(duty[c*CNT_W +: CNT_W]);
            p_flag = 0;
         end
      end
   end

   always @(negedge clock) begin
      if (model_on) begin
         chk("count",          count,          m_k / (m_pre + 1));
         chk("period_tick",    period_tick,    m_ptick);
         chk("pwm_out",        pwm_out,        m_pwm);
         chk("update_pending", update_pending, p_flag);
      end
   end

   // ---------------- stimulus helpers ----------------
   int hi [N_CH];
   int tk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic load(input int pre, input int per, input int d0, input int d1,
                       input int d2, input int d3);
      prescale_div = PRE_W'(pre);
      period       = CNT_W'(per);
      duty[0*CNT_W +: CNT_W] = CNT_W'(d0);
      duty[1*CNT_W +: CNT_W] = CNT_W'(d1);
      duty[2*CNT_W +: CNT_W] = CNT_W'(d2);
      duty[3*CNT_W +: CNT_W] = CNT_W'(d3);
      update = 1'b1;
      cyc(1);
      update = 1'b0;
   endtask

   task automatic measure(input int n);
      tk = 0;
      for (int c = 0; c < N_CH; c++) hi[c] = 0;
      repeat (n) begin
         cyc(1);
         tk += int'(period_tick);
         for (int c = 0; c < N_CH; c++) hi[c] += int'(pwm_out[c]);
      end
   endtask

   task automatic wait_ptick(input int budget, input string name);
      int b;
      b = budget;
      while (!period_tick && b > 0) begin
         cyc(1);
         b--;
      end
      chk(name, period_tick, 1);
   endtask

   task automatic wait_count(input int v, input int budget, input string name);
      int b;
      b = budget;
      while (int'(count) != v && b > 0) begin
         cyc(1);
         b--;
      end
      chk(name, count, v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int ticks;
`ifdef PWM_CENTER_ALIGN_EN
      int exp_c [9];
      int h;
`endif
      reset = 1'b1;
      cyc(2);
      chk("rst_count",       count,          0);
      chk("rst_pwm",         pwm_out,        0);
      chk("rst_period_tick", period_tick,    0);
      chk("rst_pending",     update_pending, 0);
      model_on = 1'b1;
      reset = 1'b0;

      // Basic edge-aligned: div 0, period 9, duty0 3, loaded while stopped.
      load(0, 9, 3, 0, 10, 9);
      chk("disabled_update_no_pending", update_pending, 0);
      enable = 1'b1;
      measure(20);
      chk("basic_highs_ch0", hi[0], 6);
      chk("basic_ticks",     tk,    2);
      wait_ptick(30, "basic_ptick_seen");
      measure(10);
      chk("basic_tick_gap_count", tk,          1);
      chk("basic_tick_gap_end",   period_tick, 1);

      // Duty 3 -> 7 mid-period.
      wait_count(4, 20, "dchg_reach_4");
      load(0, 9, 7, 0, 10, 9);
      chk("dchg_pending_set", update_pending, 1);
      measure(4);
      chk("dchg_old_duty_holds", hi[0], 0);
      chk("dchg_pending_hold", update_pending, 1);
      cyc(1);
      chk("dchg_wrap_tick",   period_tick,    1);
      chk("dchg_wrap_count",  count,          0);
      chk("dchg_pending_clr", update_pending, 0);
      measure(10);
      chk("dchg_new_duty", hi[0], 7);

      // Prescaler 4, period 3: count steps every 5 clocks, tick every 20.
      load(4, 3, 2, 0, 10, 9);
      wait_ptick(20, "pre_apply_tick");
      chk("pre_apply_pending", update_pending, 0);
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         chk("pre_count_step", count, i / 5);
         cyc(1);
         ticks += int'(period_tick);
      end
      chk("pre_ticks_in_20", ticks,       1);
      chk("pre_tick_at_20",  period_tick, 1);

      // duty 0 and duty period+1 across three periods.
      load(0, 9, 0, 10, 10, 9);
      wait_ptick(40, "lim_apply_tick");
      cyc(1);
      measure(30);
      chk("lim_duty0_low",   hi[0], 0);
      chk("lim_dutyhi_high", hi[1], 30);
      chk("lim_ticks",       tk,    3);

      // Pause and resume.
      enable = 1'b0;
      cyc(1);
      chk("pause_pwm",   pwm_out,     0);
      chk("pause_ptick", period_tick, 0);
      cyc(3);
      enable = 1'b1;
      cyc(15);

      // Reset at count 5 with an update pending.
      wait_count(3, 30, "rst_mid_reach_3");
      load(0, 9, 8, 8, 8, 8);
      cyc(1);
      chk("rst_mid_at5",      count,          5);
      chk("rst_mid_pending",  update_pending, 1);
      reset = 1'b1;
      cyc(1);
      chk("rst_mid_count",   count,          0);
      chk("rst_mid_pwm",     pwm_out,        0);
      chk("rst_mid_ptick",   period_tick,    0);
      chk("rst_mid_pend",    update_pending, 0);
      reset = 1'b0;
      cyc(20);
      chk("post_rst_pwm",     pwm_out,        0);
      chk("post_rst_pending", update_pending, 0);
      chk("post_rst_count",   count,          0);
      chk("post_rst_per0_tick", period_tick,  1);

`ifdef PWM_CENTER_ALIGN_EN
      model_on = 1'b0;
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      enable = 1'b0;
      center_mode = 1'b1;
      load(0, 4, 2, 0, 0, 0);
      enable = 1'b1;
      wait_ptick(20, "ctr_tick");
      exp_c = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
      h = 0;
      for (int i = 0; i < 9; i++) begin
         chk("ctr_count", count, exp_c[i]);
         if (i < 8) begin
            cyc(1);
            h += int'(pwm_out[0]);
         end
      end
      chk("ctr_period_tick", period_tick, 1);
      chk("ctr_highs", h, 4);
`endif

      model_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_generator_multi.md
PWM_GENERATOR_MULTI -- requirements
Module: pwm_generator_multi

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of PWM channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the period counter, period and duty values.
REQ-003 The block SHALL have parameter PRE_W, default 16: width of the prescaler divide value.
REQ-004 The block SHALL have port clock, input, 1: the single system clock (100 MHz); one clock, no other clock domain.
REQ-005 The block SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have port enable, input, 1: run control; 0 holds the counters and forces the outputs low.
REQ-007 The block SHALL have port prescale_div, input, PRE_W: prescaler terminal count; tick period is prescale_div+1 clocks.
REQ-008 The block SHALL have port period, input, CNT_W: main counter terminal count.
REQ-009 The block SHALL have port duty, input, N_CH*CNT_W: per-channel compare values, channel i in bits [i*CNT_W +: CNT_W].
REQ-010 The block SHALL have port update, input, 1: single-cycle strobe that captures prescale_div, period and duty.
REQ-011 The block SHALL have port update_pending, output, 1: a capture is waiting to be applied.
REQ-012 The block SHALL have port pwm_out, output, N_CH: registered PWM outputs.
REQ-013 The block SHALL have port period_tick, output, 1: one-cycle pulse at each period boundary.
REQ-014 The block SHALL have port count, output, CNT_W: current main counter value.

Function
REQ-015 Prescaler SHALL count 0..pre_sh and wrap to 0, asserting an internal tick in the cycle where it equals pre_sh; pre_sh=0 SHALL tick every clock.
REQ-016 Edge-aligned mode: on each tick, count SHALL increment, and SHALL wrap to 0 when count==per_sh; the output period is (per_sh+1)*(pre_sh+1) clocks.
REQ-017 period_tick SHALL assert for exactly one clock, in the cycle where count wraps to 0.
REQ-018 pwm_out[i] SHALL equal (count < duty_sh[i]), registered, one clock after count.
REQ-019 duty_sh[i]=0 SHALL give constant low; duty_sh[i]>per_sh SHALL give constant high, with no glitches.
REQ-020 update SHALL copy its inputs into pending registers and set update_pending; a later update before application SHALL overwrite the pending values.
REQ-021 With enable=1, pending values SHALL move to the shadows (pre_sh, per_sh, duty_sh) at the first wrap after the capture cycle, and update_pending SHALL clear in the same cycle.
REQ-022 An update in the same cycle as a wrap SHALL apply at the following wrap.
REQ-023 With enable=0, an update SHALL load the shadows on the next clock, and update_pending SHALL go high for no cycle.
REQ-024 With enable=0, the prescaler and count SHALL hold their values, and pwm_out and period_tick SHALL be 0; on re-enable, counting SHALL resume from the held values.
REQ-025 per_sh=0 SHALL keep count at 0 and assert period_tick on every tick.

Reset
REQ-026 reset SHALL clear the prescaler, count, all shadows, all pending registers, update_pending, pwm_out and period_tick to 0 on the next clock edge.
REQ-027 reset SHALL take priority over enable and update in the same cycle, including mid-period, and SHALL discard any pending update.

Configuration
REQ-028 With macro PWM_CENTER_ALIGN_EN defined, an input center_mode (1 bit, captured like period) SHALL select up/down counting 0..per_sh..0, giving a period of 2*per_sh ticks, with period_tick and shadow update at count 0 when the direction turns up.
REQ-029 Without PWM_CENTER_ALIGN_EN, center_mode and the direction logic SHALL be absent, and the block SHALL be edge-aligned only.

Structure
REQ-030 A shared package pwm_pkg SHALL hold the default CNT_W/PRE_W constants and the counter-direction enum (DIR_UP, DIR_DOWN).
REQ-031 The prescaler SHALL be the sub-module pwm_prescaler (clock, reset, enable, div, tick); the channel compares SHALL be a generate loop.

Verification
REQ-032 Verification SHALL cover: prescale_div=0, period=9, duty0=3, update, enable -> pwm_out[0] high 3 of every 10 clocks, and period_tick every 10 clocks.
REQ-033 Verification SHALL cover: prescale_div=4, period=3 -> count advances every 5 clocks, and period_tick every 20 clocks.
REQ-034 Verification SHALL cover: duty change 3->7 mid-period -> old duty holds until the wrap, new duty applies from count 0, and update_pending is high until then.
REQ-035 Verification SHALL cover: duty=0 and duty=period+1 -> constant 0 and constant 1 across 3 periods.
REQ-036 Verification SHALL cover: reset asserted at count=5 with an update pending -> all outputs are 0 the next cycle, and no stale update is applied afterwards.
REQ-037 Verification SHALL cover, with PWM_CENTER_ALIGN_EN: period=4, duty=2, center_mode=1 -> count sequence 0,1,2,3,4,3,2,1,0, and pwm_out high 4 of every 8 ticks.
